svc_pix_pattern: RTL and testbench



---
 rtl/svc_pix_pattern.sv | 167 ++++++++++++++++
 tb/tb_svc_pix_pattern.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_pix_pattern.sv
// rtl/svc_pix_pattern.sv - raster test-pattern pixel source (solid, bars, checker, gradient) on a valid/ready stream
// Optional: define SVC_PIX_PATTERN_BORDER_EN to force a white one-pixel border around every frame.
module svc_pix_pattern #(
    parameter int H_WIDTH     = 12,
    parameter int V_WIDTH     = 12,
    parameter int COLOR_WIDTH = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int CHECK_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [H_WIDTH-1:0]     h_visible,
    input  logic [V_WIDTH-1:0]     v_visible,
    input  logic [1:0]             pattern,
    input  logic [COLOR_WIDTH-1:0] solid_red,
    input  logic [COLOR_WIDTH-1:0] solid_grn,
    input  logic [COLOR_WIDTH-1:0] solid_blu,
    output logic                   m_pix_valid,
    output logic [COLOR_WIDTH-1:0] m_pix_red,
    output logic [COLOR_WIDTH-1:0] m_pix_grn,
    output logic [COLOR_WIDTH-1:0] m_pix_blu,
    output logic [H_WIDTH-1:0]     m_pix_x,
    output logic [V_WIDTH-1:0]     m_pix_y,
    output logic [ADDR_WIDTH-1:0]  m_pix_addr,
    input  logic                   m_pix_ready,
    output logic                   frame_start
);
    localparam int CW = COLOR_WIDTH;
    localparam int PW = 3 * COLOR_WIDTH;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state;
    logic [1:0]         pat_q;
    logic [PW-1:0]      solid_q;
    logic [H_WIDTH-1:0] bar_cnt;
    logic [2:0]         bar_idx;

    logic               last_x, last_y, frame_end, load_new;
    logic [H_WIDTH-1:0] nx, ld_x, nbc;
    logic [V_WIDTH-1:0] ny, ld_y;
    logic [ADDR_WIDTH-1:0] na;
    logic [2:0]         nbi, ld_bi;
    logic [1:0]         use_pat;
    logic [PW-1:0]      use_solid, col;
    logic [CW-1:0]      grad_b;

    // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [PW-1:0] bar_color(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return {{CW{rgb[2]}}, {CW{rgb[1]}}, {CW{rgb[0]}}};
    endfunction

    // Everything below describes the pixel that will be registered on the next load.
    always_comb begin
        last_x    = (m_pix_x == h_visible - H_WIDTH'(1));
        last_y    = (m_pix_y == v_visible - V_WIDTH'(1));
        frame_end = last_x && last_y;

        nx  = m_pix_x + H_WIDTH'(1);
        ny  = m_pix_y;
        nbc = bar_cnt + H_WIDTH'(1);
        nbi = bar_idx;
        if (last_x) begin
            nx  = '0;
            nbc = '0;
            nbi = '0;
            ny  = last_y ? '0 : m_pix_y + V_WIDTH'(1);
        end else if (nbc == (h_visible >> 3)) begin
            nbc = '0;
            if (bar_idx != 3'd7)
                nbi = bar_idx + 3'd1;
        end
        na = frame_end ? '0 : m_pix_addr + ADDR_WIDTH'(1);

        load_new  = (state == S_IDLE) || frame_end;
        ld_x      = (state == S_IDLE) ? '0 : nx;
        ld_y      = (state == S_IDLE) ? '0 : ny;
        ld_bi     = (state == S_IDLE) ? '0 : nbi;
        use_pat   = load_new ? pattern : pat_q;
        use_solid = load_new ? {solid_red, solid_grn, solid_blu} : solid_q;

        grad_b = ld_x[CW-1:0] + ld_y[CW-1:0];
        col    = '0;
        case (use_pat)
            2'd0:    col = use_solid;
            2'd1:    col = bar_color(ld_bi);
            2'd2:    col = (ld_x[CHECK_SHIFT] ^ ld_y[CHECK_SHIFT]) ? {PW{1'b1}} : '0;
            default: col = {ld_x[CW-1:0], ld_y[CW-1:0], grad_b};
        endcase
`ifdef SVC_PIX_PATTERN_BORDER_EN
        if (ld_x == '0 || ld_x == h_visible - H_WIDTH'(1) ||
            ld_y == '0 || ld_y == v_visible - V_WIDTH'(1))
            col = {PW{1'b1}};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pat_q       <= '0;
            solid_q     <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            m_pix_valid <= 1'b0;
            m_pix_x     <= '0;
            m_pix_y     <= '0;
            m_pix_addr  <= '0;
            frame_start <= 1'b0;
            {m_pix_red, m_pix_grn, m_pix_blu} <= '0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        pat_q       <= pattern;
                        solid_q     <= {solid_red, solid_grn, solid_blu};
                        m_pix_x     <= '0;
                        m_pix_y     <= '0;
                        m_pix_addr  <= '0;
                        bar_cnt     <= '0;
                        bar_idx     <= '0;
                        m_pix_valid <= 1'b1;
                        {m_pix_red, m_pix_grn, m_pix_blu} <= col;
                        state       <= S_RUN;
                    end
                end
                default: begin
                    if (m_pix_valid && m_pix_ready) begin
                        frame_start <= (m_pix_x == '0) && (m_pix_y == '0);
                        if (frame_end && !enable) begin
                            m_pix_valid <= 1'b0;
                            m_pix_x     <= '0;
                            m_pix_y     <= '0;
                            m_pix_addr  <= '0;
                            bar_cnt     <= '0;
                            bar_idx     <= '0;
                            state       <= S_IDLE;
                        end else begin
                            if (frame_end) begin
                                pat_q   <= pattern;
                                solid_q <= {solid_red, solid_grn, solid_blu};
                            end
                            m_pix_x    <= nx;
                            m_pix_y    <= ny;
                            m_pix_addr <= na;
                            bar_cnt    <= nbc;
                            bar_idx    <= nbi;
                            {m_pix_red, m_pix_grn, m_pix_blu} <= col;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_svc_pix_pattern.sv
// tb/tb_svc_pix_pattern.sv - directed self-checking bench for svc_pix_pattern
module tb_svc_pix_pattern;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] h_visible = 12'd16;
    logic [11:0] v_visible = 12'd4;
    logic [1:0]  pattern = 2'd0;
    logic [3:0]  solid_red = '0, solid_grn = '0, solid_blu = '0;
    logic        m_pix_valid;
    logic [3:0]  m_pix_red, m_pix_grn, m_pix_blu;
    logic [11:0] m_pix_x;
    logic [11:0] m_pix_y;
    logic [15:0] m_pix_addr;
    logic        m_pix_ready = 1'b0;
    logic        frame_start;

    int passed = 0;
    int total  = 0;

    // reference raster model
    int          mx, my, mpat;
    logic [15:0] ma;
    logic [11:0] msol;
    bit          midle = 1'b1;
    bit          mfs = 1'b0;

    svc_pix_pattern dut (
        .clk(clk), .rst(rst), .enable(enable),
        .h_visible(h_visible), .v_visible(v_visible), .pattern(pattern),
        .solid_red(solid_red), .solid_grn(solid_grn), .solid_blu(solid_blu),
        .m_pix_valid(m_pix_valid), .m_pix_red(m_pix_red), .m_pix_grn(m_pix_grn),
        .m_pix_blu(m_pix_blu), .m_pix_x(m_pix_x), .m_pix_y(m_pix_y),
        .m_pix_addr(m_pix_addr), .m_pix_ready(m_pix_ready), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_rgb(int pat, int x, int y, int h, int v, logic [11:0] sol);
        logic [11:0] c;
        int bi, s;
        s  = x + y;
        bi = x / (h / 8);
        if (bi > 7) bi = 7;
        case (pat)
            0: c = sol;
            1: case (bi)
                   0: c = 12'hFFF;  1: c = 12'hFF0;  2: c = 12'h0FF;  3: c = 12'h0F0;
                   4: c = 12'hF0F;  5: c = 12'hF00;  6: c = 12'h00F;  default: c = 12'h000;
               endcase
            2: c = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
            default: c = {x[3:0], y[3:0], s[3:0]};
        endcase
`ifdef SVC_PIX_PATTERN_BORDER_EN
        if (x == 0 || x == h - 1 || y == 0 || y == v - 1) c = 12'hFFF;
`endif
        return c;
    endfunction

    function automatic logic [53:0] obs_beat();
        if (!m_pix_valid) return {1'b0, frame_start, 52'd0};
        return {1'b1, frame_start, m_pix_x, m_pix_y, m_pix_addr, m_pix_red, m_pix_grn, m_pix_blu};
    endfunction

    function automatic logic [53:0] exp_beat();
        if (midle) return {1'b0, mfs, 52'd0};
        return {1'b1, mfs, 12'(mx), 12'(my), ma,
                exp_rgb(mpat, mx, my, int'(h_visible), int'(v_visible), msol)};
    endfunction

    task automatic start_model();
        mx = 0; my = 0; ma = '0; midle = 1'b0; mfs = 1'b0;
        mpat = int'(pattern);
        msol = {solid_red, solid_grn, solid_blu};
    endtask

    // Called at the negedge before an edge on which the current beat is accepted.
    task automatic step_model();
        mfs = (mx == 0 && my == 0);
        if (mx < int'(h_visible) - 1) mx++;
        else begin
            mx = 0;
            if (my < int'(v_visible) - 1) my++; else my = 0;
        end
        ma = ma + 16'd1;
        if (mx == 0 && my == 0) begin
            ma   = '0;
            mpat = int'(pattern);
            msol = {solid_red, solid_grn, solid_blu};
            if (!enable) midle = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; m_pix_ready = 1'b0; midle = 1'b1; mfs = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (m_pix_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_pix_valid); else passed++;
        total++; if (m_pix_x !== 12'd0) $display("FAIL reset_x: got %0d want 0", m_pix_x); else passed++;
        total++; if (m_pix_y !== 12'd0) $display("FAIL reset_y: got %0d want 0", m_pix_y); else passed++;
        total++; if (m_pix_addr !== 16'd0) $display("FAIL reset_addr: got %0d want 0", m_pix_addr); else passed++;
        total++; if ({m_pix_red, m_pix_grn, m_pix_blu} !== 12'h000)
            $display("FAIL reset_rgb: got %h want 000", {m_pix_red, m_pix_grn, m_pix_blu}); else passed++;
        total++; if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b want 0", frame_start); else passed++;
    endtask

    task automatic test_solid();
        int errs = 0, fs_cnt = 0;
        logic first_valid = 1'b0;
        logic [15:0] last_addr = 16'hFFFF;
        do_reset();
        h_visible = 12'd16; v_visible = 12'd4; pattern = 2'd0;
        solid_red = 4'd2; solid_grn = 4'd4; solid_blu = 4'd8; m_pix_ready = 1'b1;
        @(negedge clk);
        total++; if (m_pix_valid !== 1'b0) $display("FAIL solid_idle_valid: got %b want 0", m_pix_valid); else passed++;
        enable = 1'b1;
        start_model();
        for (int i = 0; i < 129; i++) begin
            @(negedge clk);
            if (i == 0) first_valid = m_pix_valid;
            fs_cnt += int'(frame_start);
            if (obs_beat() !== exp_beat()) begin
                errs++;
                if (errs == 1) $display("note solid cycle %0d obs %h exp %h", i, obs_beat(), exp_beat());
            end
            if (m_pix_valid && m_pix_x == 12'd15 && m_pix_y == 12'd3) last_addr = m_pix_addr;
            if (m_pix_valid && m_pix_ready) step_model(); else mfs = 1'b0;
        end
        total++; if (first_valid !== 1'b1) $display("FAIL solid_valid_rise: got %b want 1", first_valid); else passed++;
        total++; if (errs != 0) $display("FAIL solid_stream: got %0d bad beats want 0", errs); else passed++;
        total++; if (fs_cnt != 2) $display("FAIL solid_frame_start: got %0d pulses want 2", fs_cnt); else passed++;
        total++; if (last_addr !== 16'd63) $display("FAIL solid_last_addr: got %0d want 63", last_addr); else passed++;
    endtask

    task automatic test_backpressure();
        int errs = 0, hold_errs = 0;
        logic [53:0] prev, cur;
        bit prev_stall = 1'b0;
        do_reset();
        h_visible = 12'd12; v_visible = 12'd3; pattern = 2'd1;
        enable = 1'b1;
        start_model();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cur = obs_beat();
            if (obs_beat() !== exp_beat()) begin
                errs++;
                if (errs == 1) $display("note bp cycle %0d obs %h exp %h", i, cur, exp_beat());
            end
            if (prev_stall && {cur[53], cur[51:0]} !== {prev[53], prev[51:0]}) hold_errs++;
            m_pix_ready = 1'($urandom_range(0, 1));
            prev = cur;
            prev_stall = m_pix_valid && !m_pix_ready;
            if (m_pix_valid && m_pix_ready) step_model(); else mfs = 1'b0;
        end
        total++; if (errs != 0) $display("FAIL bp_stream: got %0d bad beats want 0", errs); else passed++;
        total++; if (hold_errs != 0) $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_errs); else passed++;
    endtask

    task automatic test_bars();
        int errs = 0;
        logic [11:0] c79 = 'x, c80 = 'x, c479 = 'x, c560 = 'x;
        do_reset();
        h_visible = 12'd640; v_visible = 12'd3; pattern = 2'd1; m_pix_ready = 1'b1;
        enable = 1'b1;
        start_model();
        for (int i = 0; i < 1921; i++) begin
            @(negedge clk);
            if (obs_beat() !== exp_beat()) begin
                errs++;
                if (errs == 1) $display("note bars cycle %0d obs %h exp %h", i, obs_beat(), exp_beat());
            end
            if (m_pix_valid && m_pix_y == 12'd1) begin
                if (m_pix_x == 12'd79)  c79  = {m_pix_red, m_pix_grn, m_pix_blu};
                if (m_pix_x == 12'd80)  c80  = {m_pix_red, m_pix_grn, m_pix_blu};
                if (m_pix_x == 12'd479) c479 = {m_pix_red, m_pix_grn, m_pix_blu};
                if (m_pix_x == 12'd560) c560 = {m_pix_red, m_pix_grn, m_pix_blu};
            end
            if (m_pix_valid && m_pix_ready) step_model(); else mfs = 1'b0;
        end
        total++; if (errs != 0) $display("FAIL bars_stream: got %0d bad beats want 0", errs); else passed++;
        total++; if (c79 !== 12'hFFF) $display("FAIL bars_x79: got %h want FFF", c79); else passed++;
        total++; if (c80 !== 12'hFF0) $display("FAIL bars_x80: got %h want FF0", c80); else passed++;
        total++; if (c479 !== 12'hF00) $display("FAIL bars_x479: got %h want F00", c479); else passed++;
        total++; if (c560 !== 12'h000) $display("FAIL bars_x560: got %h want 000", c560); else passed++;
    endtask

    task automatic test_pattern_change();
        int errs = 0, fr = 0;
        logic [11:0] c55 = 'x, c00 = 'x, c80 = 'x, c88 = 'x;
        logic [11:0] want00;
        logic [11:0] want80;
        do_reset();
        h_visible = 12'd16; v_visible = 12'd16; pattern = 2'd0;
        solid_red = 4'd1; solid_grn = 4'd2; solid_blu = 4'd3; m_pix_ready = 1'b1;
        enable = 1'b1;
        start_model();
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (i == 20) pattern = 2'd2;
            if (obs_beat() !== exp_beat()) begin
                errs++;
                if (errs == 1) $display("note pat cycle %0d obs %h exp %h", i, obs_beat(), exp_beat());
            end
            if (m_pix_valid && m_pix_x == 12'd0 && m_pix_y == 12'd0) fr++;
            if (m_pix_valid && fr == 1 && m_pix_x == 12'd5 && m_pix_y == 12'd5) c55 = {m_pix_red, m_pix_grn, m_pix_blu};
            if (m_pix_valid && fr == 2) begin
                if (m_pix_x == 12'd0 && m_pix_y == 12'd0) c00 = {m_pix_red, m_pix_grn, m_pix_blu};
                if (m_pix_x == 12'd8 && m_pix_y == 12'd0) c80 = {m_pix_red, m_pix_grn, m_pix_blu};
                if (m_pix_x == 12'd8 && m_pix_y == 12'd8) c88 = {m_pix_red, m_pix_grn, m_pix_blu};
            end
            if (m_pix_valid && m_pix_ready) step_model(); else mfs = 1'b0;
        end
`ifdef SVC_PIX_PATTERN_BORDER_EN
        want00 = 12'hFFF;
`else
        want00 = 12'h000;
`endif
        want80 = 12'hFFF;
        total++; if (errs != 0) $display("FAIL pat_stream: got %0d bad beats want 0", errs); else passed++;
        total++; if (c55 !== 12'h123) $display("FAIL pat_still_solid: got %h want 123", c55); else passed++;
        total++; if (c00 !== want00) $display("FAIL pat_chk_0_0: got %h want %h", c00, want00); else passed++;
        total++; if (c80 !== want80) $display("FAIL pat_chk_8_0: got %h want %h", c80, want80); else passed++;
        total++; if (c88 !== 12'h000) $display("FAIL pat_chk_8_8: got %h want 000", c88); else passed++;
    endtask

    task automatic test_enable_drop();
        int errs = 0, acc_cnt = 0;
        logic [11:0] lx = 'x, ly = 'x;
        do_reset();
        h_visible = 12'd16; v_visible = 12'd8; pattern = 2'd3; m_pix_ready = 1'b1;
        enable = 1'b1;
        start_model();
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (obs_beat() !== exp_beat()) begin
                errs++;
                if (errs == 1) $display("note drop cycle %0d obs %h exp %h", i, obs_beat(), exp_beat());
            end
            if (m_pix_valid && m_pix_y == 12'd3) enable = 1'b0;
            if (m_pix_valid && m_pix_ready) begin
                acc_cnt++; lx = m_pix_x; ly = m_pix_y;
                step_model();
            end else mfs = 1'b0;
        end
        total++; if (errs != 0) $display("FAIL drop_stream: got %0d bad beats want 0", errs); else passed++;
        total++; if (acc_cnt != 128) $display("FAIL drop_beats: got %0d want 128", acc_cnt); else passed++;
        total++; if ({lx, ly} !== {12'd15, 12'd7}) $display("FAIL drop_last_pix: got (%0d,%0d) want (15,7)", lx, ly); else passed++;
        total++; if (m_pix_valid !== 1'b0) $display("FAIL drop_idle_valid: got %b want 0", m_pix_valid); else passed++;
        enable = 1'b1;
        start_model();
        @(negedge clk);
        total++; if (obs_beat() !== exp_beat()) $display("FAIL drop_restart: got %h want %h", obs_beat(), exp_beat()); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        h_visible = 12'd16; v_visible = 12'd4; pattern = 2'd3; m_pix_ready = 1'b1;
        enable = 1'b1;
        repeat (6) @(negedge clk);
        total++; if ({m_pix_valid, m_pix_x} !== {1'b1, 12'd5})
            $display("FAIL rmid_pre: got valid %b x %0d want valid 1 x 5", m_pix_valid, m_pix_x); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (m_pix_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", m_pix_valid); else passed++;
        total++; if ({m_pix_x, m_pix_y} !== 24'd0) $display("FAIL rmid_xy: got (%0d,%0d) want (0,0)", m_pix_x, m_pix_y); else passed++;
        total++; if (m_pix_addr !== 16'd0) $display("FAIL rmid_addr: got %0d want 0", m_pix_addr); else passed++;
        total++; if ({m_pix_red, m_pix_grn, m_pix_blu} !== 12'h000)
            $display("FAIL rmid_rgb: got %h want 000", {m_pix_red, m_pix_grn, m_pix_blu}); else passed++;
        rst = 1'b0; enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_solid();
        test_backpressure();
        test_bars();
        test_pattern_change();
        test_enable_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
